// File: rtl/alu_nzcv_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle NZCV ALU.
package alu_nzcv_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_ADC = 3'b100,
        OP_SBC = 3'b101,
        OP_MUL = 3'b110,
        OP_EOR = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_nzcv_mc_if.sv
// Request/response bundle between a requester and the NZCV ALU.
interface alu_nzcv_mc_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_op;
    logic         i_set_flags;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic [N-1:0] o_result;
    logic         o_valid;
    logic [3:0]   o_nzcv;

    modport master (
        output i_valid, i_op, i_set_flags, i_a, i_b,
        input  o_ready, o_result, o_valid, o_nzcv
    );

    modport slave (
        input  i_valid, i_op, i_set_flags, i_a, i_b,
        output o_ready, o_result, o_valid, o_nzcv
    );
endinterface

// File: rtl/alu_nzcv_adder.sv
// N-bit adder with carry-in, producing carry-out and signed overflow.
module alu_nzcv_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    logic [N:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum  = full[N-1:0];
    assign cout = full[N];
    // Overflow when both addends share a sign that the sum does not.
    assign ovf  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
endmodule

// File: rtl/alu_nzcv_mc.sv
// ALU with NZCV flag register: single-cycle add/sub/logic ops, N-cycle shift-add multiply.
module alu_nzcv_mc
    import alu_nzcv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    alu_nzcv_mc_if.slave   bus
);
    localparam int CW = $clog2(N);

    state_e       state, state_next;
    op_e          op;
    logic         accept;
    logic [CW-1:0] cnt;
    logic [N-1:0] mcand, mplier, acc, acc_step;
    logic         mul_last, mul_flags;
    logic [N-1:0] result;
    logic [3:0]   nzcv;
    logic         out_valid;

    logic [N-1:0] add_b, add_sum;
    logic         add_cin, add_cout, add_ovf;
    logic [N-1:0] alu_res;
    logic         alu_c, alu_v;

    assign op     = op_e'(bus.i_op);
    assign accept = bus.i_valid && (state == ST_IDLE);

    assign bus.o_ready  = (state == ST_IDLE);
    assign bus.o_result = result;
    assign bus.o_valid  = out_valid;
    assign bus.o_nzcv   = nzcv;

    // Subtracts feed the inverted operand; the carry-in selects +1 or the C flag.
    assign add_b = (op == OP_SUB || op == OP_SBC) ? ~bus.i_b : bus.i_b;

    always_comb begin
        add_cin = 1'b0;
        case (op)
            OP_SUB:         add_cin = 1'b1;
            OP_ADC, OP_SBC: add_cin = nzcv[1];
            default:        add_cin = 1'b0;
        endcase
    end

    alu_nzcv_adder #(.N(N)) u_adder (
        .a    (bus.i_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res = add_sum;
                alu_c   = add_cout;
                alu_v   = add_ovf;
            end
            OP_AND:  alu_res = bus.i_a & bus.i_b;
            OP_OR:   alu_res = bus.i_a | bus.i_b;
            OP_EOR:  alu_res = bus.i_a ^ bus.i_b;
            default: alu_res = '0;
        endcase
    end

    // Bit 0 of the multiplier is consumed at acceptance, bits 1..N-1 in the MUL state.
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && op == OP_MUL) state_next = ST_MUL;
            ST_MUL:  if (mul_last)               state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mul_flags <= 1'b0;
            result    <= '0;
            nzcv      <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept && op == OP_MUL) begin
                    mcand     <= bus.i_a << 1;
                    mplier    <= bus.i_b >> 1;
                    acc       <= bus.i_b[0] ? bus.i_a : '0;
                    cnt       <= CW'(N - 1);
                    mul_flags <= bus.i_set_flags;
                end else if (accept) begin
                    result    <= alu_res;
                    out_valid <= 1'b1;
                    if (bus.i_set_flags)
                        nzcv <= {alu_res[N-1], alu_res == '0, alu_c, alu_v};
                end
            end else begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_step;
                cnt    <= cnt - CW'(1);
                if (mul_last) begin
                    result    <= acc_step;
                    out_valid <= 1'b1;
                    if (mul_flags)
                        nzcv <= {acc_step[N-1], acc_step == '0, nzcv[1:0]};
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_nzcv_mc.sv
// Self-checking bench for alu_nzcv_mc (N=32) with a behavioural flag/result model.
module tb_alu_nzcv_mc;
    localparam int N = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] m_result;
    logic [3:0]  m_nzcv;

    alu_nzcv_mc_if #(.N(N)) bus ();

    alu_nzcv_mc #(.N(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf);
        bus.i_valid     = v;
        bus.i_op        = op;
        bus.i_a         = a;
        bus.i_b         = b;
        bus.i_set_flags = sf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: arithmetic on wide integers, carries as unsigned comparisons.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf);
        longint unsigned ua, ub, us, p;
        longint sa, sb, sr, cfl;
        logic [31:0] r;
        logic c, v;
        ua  = a;
        ub  = b;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cfl = m_nzcv[1] ? 1 : 0;
        c   = m_nzcv[1];
        v   = m_nzcv[0];
        r   = '0;
        sr  = 0;
        case (op)
            3'd0: begin us = ua + ub;                   r = us[31:0]; c = (us > 64'hFFFF_FFFF); sr = sa + sb; end
            3'd1: begin r = a - b;                      c = (ua >= ub);                        sr = sa - sb; end
            3'd4: begin us = ua + ub + longint'(cfl);   r = us[31:0]; c = (us > 64'hFFFF_FFFF); sr = sa + sb + cfl; end
            3'd5: begin r = a - b - 32'd1 + 32'(cfl);   c = (ua + longint'(cfl) > ub);         sr = sa - sb - 1 + cfl; end
            3'd2: begin r = a & b; c = 1'b0; v = 1'b0; end
            3'd3: begin r = a | b; c = 1'b0; v = 1'b0; end
            3'd7: begin r = a ^ b; c = 1'b0; v = 1'b0; end
            default: begin p = ua * ub; r = p[31:0]; end
        endcase
        if (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)
            v = (sr > SMAX) || (sr < SMIN);
        m_result = r;
        if (sf) m_nzcv = {r[31], r == 32'd0, c, v};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'd0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        tick();
        tick();
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b0000) begin failures++; $display("FAIL reset_nzcv got=%b exp=0000", bus.o_nzcv); end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        m_result = '0;
        m_nzcv   = '0;
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_directed();
        drive(1'b1, 3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        model_op(3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        tick();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", bus.o_valid); end
        checks++; if (bus.o_result !== 32'd0) begin failures++; $display("FAIL add_result got=%h exp=0", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b0110) begin failures++; $display("FAIL add_nzcv got=%b exp=0110", bus.o_nzcv); end

        drive(1'b1, 3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        model_op(3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        tick();
        checks++; if (bus.o_result !== 32'h0000_FFFF) begin failures++; $display("FAIL sub_result got=%h exp=0000ffff", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b0010) begin failures++; $display("FAIL sub_nzcv got=%b exp=0010", bus.o_nzcv); end
        drive(1'b1, 3'd4, 32'd0, 32'd0, 1'b1);
        model_op(3'd4, 32'd0, 32'd0, 1'b1);
        tick();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd1) begin failures++; $display("FAIL adc_b2b_result got=%h/%b exp=1/1", bus.o_result, bus.o_valid); end
        checks++; if (bus.o_nzcv !== 4'b0000) begin failures++; $display("FAIL adc_b2b_nzcv got=%b exp=0000", bus.o_nzcv); end

        drive(1'b1, 3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        model_op(3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        model_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        checks++; if (bus.o_result !== 32'h8000_0000) begin failures++; $display("FAIL add_noflags_result got=%h exp=80000000", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b0010) begin failures++; $display("FAIL add_noflags_nzcv got=%b exp=0010", bus.o_nzcv); end

        drive(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        model_op(3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        tick();
        checks++; if (bus.o_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL eor_result got=%h exp=ffffffff", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b1000) begin failures++; $display("FAIL eor_nzcv got=%b exp=1000", bus.o_nzcv); end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL hold got=%h/%b exp=ffffffff/0", bus.o_result, bus.o_valid); end
    endtask

    task automatic test_mul();
        int busy_bad;
        busy_bad = 0;
        drive(1'b1, 3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        model_op(3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b1, 3'd6, 32'h0001_0000, 32'h0001_0001, 1'b1);
        model_op(3'd6, 32'h0001_0000, 32'h0001_0001, 1'b1);
        tick();
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int k = 1; k <= 31; k++) begin
            if (k > 1) tick();
            if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) busy_bad++;
        end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL mul_busy bad_cycles=%0d exp=0", busy_bad); end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL mul_done valid=%b ready=%b exp=1/1", bus.o_valid, bus.o_ready); end
        checks++; if (bus.o_result !== 32'h0001_0000) begin failures++; $display("FAIL mul_result got=%h exp=00010000", bus.o_result); end
        checks++; if (bus.o_nzcv !== 4'b0010) begin failures++; $display("FAIL mul_nzcv got=%b exp=0010", bus.o_nzcv); end
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mul_pulse got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        seen = 0;
        drive(1'b1, 3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        model_op(3'd1, 32'h0001_0000, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b1, 3'd6, 32'h0000_0003, 32'h0000_0005, 1'b1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int k = 2; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_result = '0;
        m_nzcv   = '0;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_nzcv !== 4'b0000) begin failures++; $display("FAIL rst_mul_state valid=%b nzcv=%b exp=0/0000", bus.o_valid, bus.o_nzcv); end
        tick();
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL rst_mul_ready got=%b exp=1", bus.o_ready); end
        for (int k = 0; k < 40; k++) begin
            if (bus.o_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0 || bus.o_nzcv !== 4'b0000) begin failures++; $display("FAIL rst_mul_novalid pulses=%0d nzcv=%b exp=0/0000", seen, bus.o_nzcv); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
            a  = pick_operand();
            b  = pick_operand();
            drive(1'b1, op, a, b, 1'b1);
            model_op(op, a, b, 1'b1);
            tick();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== m_result || bus.o_nzcv !== m_nzcv) begin
                failures++;
                $display("FAIL b2b_carry op=%0d got=%h/%b/%b exp=%h/%b/1", op, bus.o_result, bus.o_nzcv, bus.o_valid, m_result, m_nzcv);
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        logic sf;
        int cycles;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                drive(1'b0, $urandom_range(0, 7), $urandom, $urandom, 1'b1);
                tick();
                checks++;
                if (bus.o_valid !== 1'b0 || bus.o_result !== m_result || bus.o_nzcv !== m_nzcv) begin
                    failures++;
                    $display("FAIL rnd_idle got=%h/%b/%b exp=%h/%b/0", bus.o_result, bus.o_nzcv, bus.o_valid, m_result, m_nzcv);
                end
                continue;
            end
            if ($urandom_range(0, 9) == 0) op = 3'd6;
            else begin
                op = 3'($urandom_range(0, 6));
                if (op == 3'd6) op = 3'd7;
            end
            a  = pick_operand();
            b  = pick_operand();
            sf = 1'($urandom_range(0, 1));
            drive(1'b1, op, a, b, sf);
            model_op(op, a, b, sf);
            tick();
            if (op == 3'd6) begin
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
                cycles = 1;
                while (bus.o_valid !== 1'b1 && cycles < 40) begin
                    tick();
                    cycles++;
                end
                checks++; if (cycles != N) begin failures++; $display("FAIL rnd_mul_latency got=%0d exp=%0d", cycles, N); end
            end
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_result !== m_result || bus.o_nzcv !== m_nzcv) begin
                failures++;
                $display("FAIL rnd_op op=%0d a=%h b=%h sf=%b got=%h/%b/%b exp=%h/%b/1", op, a, b, sf, bus.o_result, bus.o_nzcv, bus.o_valid, m_result, m_nzcv);
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_result = '0;
        m_nzcv   = '0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_directed();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
